// File: rtl/mul_div_pkg.sv
// mul_div_pkg: op encodings and FSM states shared by the multiply/divide unit
package mul_div_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: issue/result bundle between control unit and mul_div_unit; MUL_DIV_HILO_WRITE_EN adds mthi/mtlo signals
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MUL_DIV_HILO_WRITE_EN
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    modport master (output start, op, a, b, wr_hi, wr_lo, wdata,
                    input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, op, a, b, wr_hi, wr_lo, wdata,
                    output busy, done, div_by_zero, hi, lo);
`else
    modport master (output start, op, a, b,
                    input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, op, a, b,
                    output busy, done, div_by_zero, hi, lo);
`endif
endinterface

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational iteration, shift-add multiply or restoring-divide trial subtract
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_nx
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc[0]}}};
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        ge      = rem_sh >= {1'b0, mcand};
        // when ge holds the true difference is below the divisor, so W bits suffice
        rem_sub = rem_sh[WIDTH-1:0] - mcand;
        acc_nx  = !is_div ? {sum, acc[WIDTH-1:1]}
                          : {ge ? rem_sub : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide with HI/LO registers; MUL_DIV_HILO_WRITE_EN adds mthi/mtlo writes
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_e             state, state_nx;
    op_e                op_in;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nx, prod_fix;
    logic [WIDTH-1:0]   mcand, a_raw, hi, lo, abs_a, abs_b, hi_fix, lo_fix;
    logic               is_div, neg_q, neg_r, dz, sgn, div_in, accept, busy;
    assign op_in  = op_e'(bus.op);
    assign sgn    = op_in == OP_MULT || op_in == OP_DIV;
    assign div_in = op_in == OP_DIV || op_in == OP_DIVU;
    assign abs_a  = sgn && bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b  = sgn && bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);
    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .mcand  (mcand),
        .acc_nx (acc_nx)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        busy     = state == ST_CALC || state == ST_FIX;
        state_nx = accept            ? ST_CALC
                 : state == ST_CALC  ? (cnt == '0 ? ST_FIX : ST_CALC)
                 : state == ST_FIX   ? ST_DONE
                 : state == ST_DONE  ? ST_IDLE
                 : state;
    end
    // divide by zero returns all-ones quotient and the untouched dividend
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        hi_fix   = !is_div ? prod_fix[2*WIDTH-1:WIDTH]
                 : dz      ? a_raw
                 : neg_r   ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        lo_fix   = !is_div ? prod_fix[WIDTH-1:0]
                 : dz      ? '1
                 : neg_q   ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (accept) begin
                is_div <= div_in;
                mcand  <= div_in ? abs_b : abs_a;
                acc    <= {{WIDTH{1'b0}}, div_in ? abs_a : abs_b};
                a_raw  <= bus.a;
                cnt    <= CW'(WIDTH - 1);
                neg_q  <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r  <= sgn && bus.a[WIDTH-1];
                dz     <= div_in && bus.b == '0;
            end else if (state == ST_CALC) begin
                acc <= acc_nx;
                cnt <= cnt - 1'b1;
            end
            if (state == ST_FIX) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
`ifdef MUL_DIV_HILO_WRITE_EN
            if (!busy && bus.wr_hi) hi <= bus.wdata;
            if (!busy && bus.wr_lo) lo <= bus.wdata;
`endif
        end
    end
    assign bus.busy        = busy;
    assign bus.done        = state == ST_DONE;
    assign bus.div_by_zero = state == ST_DONE && dz;
    assign bus.hi          = hi;
    assign bus.lo          = lo;
endmodule
